// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between the E-stage pipeline and the multiply/divide sequencer.
// The pipeline holds the master side; the sequencer holds the slave side.
interface mdu_ctrl_if;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        rd_hi;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   modport master (
      output start, mdu_op, in1, in2, rd_hi,
      input  busy, stall, hi, lo, rdata
   );

   modport slave (
      input  start, mdu_op, in1, in2, rd_hi,
      output busy, stall, hi, lo, rdata
   );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: computes the result when the command is accepted,
// holds busy for a fixed latency, then commits the result into HI/LO.
//
// state  | meaning
// S_IDLE | free; accepts MULT*/DIV* (go to S_RUN) or MTHI/MTLO (write at once)
// S_RUN  | long op in flight; counter runs down, commit to HI/LO at zero
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_ctrl_if.slave  bus
);

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     hi_q, lo_q;
   logic [31:0]     pend_hi_q, pend_lo_q;
   logic            pend_wr_q;
   logic            latch, commit, wr_hi, wr_lo;

   logic            is_div, is_uns;
   logic [63:0]     mul_a, mul_b, product;
   logic            a_neg, b_neg;
   logic [31:0]     a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
   logic [31:0]     res_hi, res_lo;

   assign is_div = bus.mdu_op[1];
   assign is_uns = bus.mdu_op[0];

   // One 64x64 multiplier serves both flavours: the low 64 bits of the
   // product of the extended operands are correct for signed and unsigned.
   assign mul_a   = is_uns ? {32'b0, bus.in1} : {{32{bus.in1[31]}}, bus.in1};
   assign mul_b   = is_uns ? {32'b0, bus.in2} : {{32{bus.in2[31]}}, bus.in2};
   assign product = mul_a * mul_b;

   // Signed divide through magnitudes; this also yields 0x80000000 / -1 = 0x80000000 r 0.
   assign a_neg  = ~is_uns & bus.in1[31];
   assign b_neg  = ~is_uns & bus.in2[31];
   assign a_mag  = a_neg ? (32'd0 - bus.in1) : bus.in1;
   assign b_mag  = b_neg ? (32'd0 - bus.in2) : bus.in2;
   assign b_safe = (bus.in2 == 32'd0) ? 32'd1 : b_mag;
   assign q_mag  = a_mag / b_safe;
   assign r_mag  = a_mag % b_safe;
   assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

   assign res_hi = is_div ? rem  : product[63:32];
   assign res_lo = is_div ? quot : product[31:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      commit  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (!bus.mdu_op[2]) begin
                  latch   = 1'b1;
                  state_d = S_RUN;
                  cnt_d   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
               end else if (bus.mdu_op == OP_MTHI) begin
                  wr_hi = 1'b1;
               end else if (bus.mdu_op == OP_MTLO) begin
                  wr_lo = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               commit  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            pend_hi_q <= res_hi;
            pend_lo_q <= res_lo;
            pend_wr_q <= ~(is_div && (bus.in2 == 32'd0));
         end
         if (commit && pend_wr_q) begin
            hi_q <= pend_hi_q;
            lo_q <= pend_lo_q;
         end
         if (wr_hi) hi_q <= bus.in1;
         if (wr_lo) lo_q <= bus.in1;
      end
   end

   assign bus.busy  = (state_q == S_RUN);
   assign bus.stall = bus.busy | (bus.start & ~bus.mdu_op[2]);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.rdata = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a vector table of commands from idle plus
// hand-written sequences for busy-time starts, commit-cycle starts and reset.
module tb_mdu_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mdu_ctrl_if bus ();

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          exp_busy;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.start  = 1'b0;
      bus.mdu_op = 3'b110;
      bus.in1    = 32'd0;
      bus.in2    = 32'd0;
   endtask

   // Present a command for one cycle; returns just after its accepting edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mdu_op = op;
      bus.in1    = a;
      bus.in2    = b;
      @(posedge clk);
      #1;
      drive_idle();
   endtask

   // Counts cycles with busy high, starting just after an edge; bounded.
   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
      check({name, " hi"}, bus.hi, eh);
      check({name, " lo"}, bus.lo, el);
      bus.rd_hi = 1'b1;
      #1;
      check({name, " rdata_hi"}, bus.rdata, eh);
      bus.rd_hi = 1'b0;
      #1;
      check({name, " rdata_lo"}, bus.rdata, el);
   endtask

   initial begin
      int n;

      vecs[0]  = '{"mult_neg",     3'b000, 32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{"multu",        3'b001, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{"div_negdiv",   3'b010, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      vecs[3]  = '{"divu_zero",    3'b011, 32'd5,        32'd0,        10, 32'h00000001, 32'hFFFFFFFD};
      vecs[4]  = '{"mthi",         3'b100, 32'h12345678, 32'd0,        0,  32'h12345678, 32'hFFFFFFFD};
      vecs[5]  = '{"mtlo",         3'b101, 32'hCAFEBABE, 32'd0,        0,  32'h12345678, 32'hCAFEBABE};
      vecs[6]  = '{"op_none",      3'b110, 32'h55555555, 32'd3,        0,  32'h12345678, 32'hCAFEBABE};
      vecs[7]  = '{"div_ovf",      3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vecs[8]  = '{"div_negdvd",   3'b010, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[9]  = '{"divu_big",     3'b011, 32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC};
      vecs[10] = '{"mult_m1m1",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
      vecs[11] = '{"multu_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};

      drive_idle();
      bus.rd_hi = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset stall", {31'd0, bus.stall}, 32'd0);
      check_hilo("reset", 32'd0, 32'd0);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.start  = 1'b1;
         bus.mdu_op = vecs[i].op;
         bus.in1    = vecs[i].a;
         bus.in2    = vecs[i].b;
         #1;
         check({vecs[i].name, " stall"}, {31'd0, bus.stall}, {31'd0, ~vecs[i].op[2]});
         @(posedge clk);
         #1;
         drive_idle();
         count_busy(n);
         check({vecs[i].name, " busy_cycles"}, n, vecs[i].exp_busy);
         check_hilo(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
      end

      // MTLO while busy is ignored; stall stays asserted
      issue(3'b000, 32'd3, 32'd4);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mdu_op = 3'b101;
      bus.in1    = 32'hDEADBEEF;
      #1;
      check("mtlo_busy stall", {31'd0, bus.stall}, 32'd1);
      @(posedge clk);
      #1;
      drive_idle();
      count_busy(n);
      check("mtlo_busy busy_cycles", n, 32'd4);
      check_hilo("mtlo_busy", 32'd0, 32'd12);

      // Second MULT pulse in busy cycle 3 of a DIV is ignored
      issue(3'b010, 32'd100, 32'd7);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.start  = 1'b1;
      bus.mdu_op = 3'b000;
      bus.in1    = 32'd2;
      bus.in2    = 32'd3;
      @(posedge clk);
      #1;
      drive_idle();
      count_busy(n);
      check("div_then_mult busy_cycles", n + 3, 32'd10);
      check_hilo("div_then_mult", 32'd2, 32'd14);
      check("div_then_mult idle_after", {31'd0, bus.busy}, 32'd0);

      // MTHI in the commit cycle is dropped
      issue(3'b000, 32'd5, 32'd6);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("commit_cycle busy", {31'd0, bus.busy}, 32'd1);
      bus.start  = 1'b1;
      bus.mdu_op = 3'b100;
      bus.in1    = 32'hAAAA5555;
      @(posedge clk);
      #1;
      drive_idle();
      check("commit_cycle busy_after", {31'd0, bus.busy}, 32'd0);
      check_hilo("commit_cycle", 32'd0, 32'd30);

      // Reset in busy cycle 2 aborts the MULT
      issue(3'b101, 32'h0BADF00D, 32'd0);
      issue(3'b000, 32'd9, 32'd9);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check_hilo("abort", 32'd0, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("abort no_commit busy", {31'd0, bus.busy}, 32'd0);
      check_hilo("abort no_commit", 32'd0, 32'd0);

      // Reset wins over a simultaneous start
      issue(3'b100, 32'h77777777, 32'd0);
      check("pre_reset hi", bus.hi, 32'h77777777);
      @(negedge clk);
      reset      = 1'b1;
      bus.start  = 1'b1;
      bus.mdu_op = 3'b000;
      bus.in1    = 32'd3;
      bus.in2    = 32'd3;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive_idle();
      check("reset_vs_start busy", {31'd0, bus.busy}, 32'd0);
      check_hilo("reset_vs_start", 32'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
